// File: rtl/vec_mult_pkg.sv
// Shared types and widths for the vector-multiplier datapath.
// Holds default sizes, derived-width helpers and the accumulator FSM states.
package vec_mult_pkg;

  localparam int VM_N       = 8;
  localparam int VM_MAX_LEN = 16;

  // Accumulator width: a full product plus enough headroom for MAX_LEN terms.
  function automatic int acc_w(input int n, input int max_len);
    return 2 * n + $clog2(max_len);
  endfunction

  // Element-count width: must be able to represent MAX_LEN itself.
  function automatic int cnt_w(input int max_len);
    return $clog2(max_len + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/vec_dot_acc.sv
// Dot-product accumulator stage fed by the array multiplier.
// Sums a product stream per vector; result on a valid/ready port.
module vec_dot_acc
  import vec_mult_pkg::*;
#(
  parameter int N       = VM_N,
  parameter int MAX_LEN = VM_MAX_LEN,
  parameter int ACC_W   = acc_w(N, MAX_LEN),
  parameter int CNT_W   = cnt_w(MAX_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   in_p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_trunc
);

  acc_state_t state_q, state_d;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_trunc_q, out_trunc_d;

  logic             take;
  logic             first;
  logic             hs;
  logic [ACC_W-1:0] acc_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             at_max;
  logic             term;

  // Beat acceptance and per-beat arithmetic.
  always_comb begin
    in_ready = ~rst & (~out_valid_q | out_ready);
    take     = in_valid & in_ready;
    hs       = out_valid_q & out_ready;
    first    = (state_q != ACCUM);
    acc_nxt  = (first ? '0 : acc_q) + ACC_W'(in_p);
    cnt_nxt  = first ? CNT_W'(1) : cnt_q + CNT_W'(1);
    at_max   = (cnt_nxt == CNT_W'(MAX_LEN));
    term     = in_last | at_max;
  end

  // Next-state logic for FSM, running sum and result register.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_trunc_d = out_trunc_q;

    if (take) begin
      acc_d = acc_nxt;
      cnt_d = cnt_nxt;
    end

    unique case (state_q)
      IDLE: begin
        if (take) state_d = term ? DONE : ACCUM;
      end
      ACCUM: begin
        if (take && term) state_d = DONE;
      end
      DONE: begin
        if (hs) begin
          if (take) state_d = term ? DONE : ACCUM;
          else      state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (hs) out_valid_d = 1'b0;

    if (take && term) begin
      out_valid_d = 1'b1;
      out_sum_d   = acc_nxt;
      out_count_d = cnt_nxt;
      out_trunc_d = at_max & ~in_last;
    end
  end

  // State, accumulator and result registers with sync reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_trunc = out_trunc_q;

endmodule
